// File: rtl/fpro_bus_master_if.sv
// Command, response and FPro MMIO bus signals of the bus master, grouped as one bundle.
interface fpro_bus_master_if;
  // Valid/ready: a command (or response) transfers on a clock edge where both
  // valid and ready are high. The offering side holds valid and its payload
  // stable until that edge; ready may be high before valid rises.
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [20:0] rsp_addr;

  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_addr,
    input  rsp_ready,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_addr,
    output rsp_ready,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data
  );
endinterface

// File: rtl/fpro_bus_master.sv
// FPro MMIO initiator: buffers read/write commands in a FIFO, issues them as
// single-cycle bus strobes in order, and returns read data on a response port.
module fpro_bus_master #(
  parameter int CMD_DEPTH_BIT = 3,
  parameter int RD_LAT        = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  fpro_bus_master_if.master      bus,
  output logic                   busy,
  output logic [CMD_DEPTH_BIT:0] cmd_count,
  output logic [1:0]             dbg_state
);

  localparam int DEPTH = 1 << CMD_DEPTH_BIT;
  localparam logic [CMD_DEPTH_BIT:0] DEPTH_CNT = (CMD_DEPTH_BIT+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RSP = 2'd2} state_t;

  state_t state, state_next;

  logic [53:0]              fifo_mem [DEPTH];
  logic [CMD_DEPTH_BIT-1:0] wr_ptr, rd_ptr;
  logic [CMD_DEPTH_BIT:0]   count;
  logic                     full, empty, push, pop, capture;
  logic                     head_write;
  logic [20:0]              head_addr;
  logic [31:0]              head_wdata;

  logic        cs_q, wr_q, rd_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_data_q;
  logic [20:0] rsp_addr_q;
  logic [1:0]  lat_cnt;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && !full;
  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr];

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CMD_DEPTH_BIT'(1);
      if (pop)  rd_ptr <= rd_ptr + CMD_DEPTH_BIT'(1);
      if (push && !pop)      count <= count + (CMD_DEPTH_BIT+1)'(1);
      else if (pop && !push) count <= count - (CMD_DEPTH_BIT+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && !head_write) state_next = RD_WAIT;
      RD_WAIT: if (lat_cnt == 2'd0) state_next = RSP;
      RSP:     if (bus.rsp_ready) state_next = (!empty && !head_write) ? RD_WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The next command may be popped in the same cycle the response is accepted.
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:    pop     = !empty;
      RD_WAIT: capture = (lat_cnt == 2'd0);
      RSP:     pop     = bus.rsp_ready && !empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      lat_cnt    <= '0;
    end else begin
      cs_q <= pop;
      wr_q <= pop && head_write;
      rd_q <= pop && !head_write;
      if (pop) begin
        addr_q  <= head_addr;
        lat_cnt <= 2'(RD_LAT);
        if (head_write) wdata_q <= head_wdata;
      end else if (state == RD_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (capture) begin
        rsp_data_q <= bus.mmio_rd_data;
        rsp_addr_q <= addr_q;
      end
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.rsp_valid    = (state == RSP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wdata_q;

  assign busy      = (count != '0) || cs_q || (state != IDLE);
  assign cmd_count = count;
  assign dbg_state = state;

endmodule

// File: tb/tb_fpro_bus_master.sv
// Directed bench for fpro_bus_master: one instance with RD_LAT=0, one with RD_LAT=2,
// checked with immediate assertions against hand-computed values.
module tb_fpro_bus_master;

  logic       clk;
  logic       reset;
  logic       busy0, busy2;
  logic [3:0] cnt0, cnt2;
  logic [1:0] dbg0, dbg2;
  int         cyc;
  int         checks;
  int         errors;

  fpro_bus_master_if bus0 ();
  fpro_bus_master_if bus2 ();

  fpro_bus_master #(.CMD_DEPTH_BIT(3), .RD_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .cmd_count(cnt0), .dbg_state(dbg0)
  );

  fpro_bus_master #(.CMD_DEPTH_BIT(3), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .busy(busy2), .cmd_count(cnt2), .dbg_state(dbg2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- bus models ----------------
  // Zero-latency slave: data is valid only in the strobe cycle.
  assign bus0.mmio_rd_data = bus0.mmio_rd ? (32'h12345678 ^ {11'h0, bus0.mmio_addr ^ 21'h0C0})
                                          : 32'hBAD0BAD0;

  // Two-cycle slave: data is valid only two cycles after the strobe cycle.
  logic        d1, d2;
  logic [20:0] a1, a2;
  always @(posedge clk) begin
    d1 <= bus2.mmio_rd;
    a1 <= bus2.mmio_addr;
    d2 <= d1;
    a2 <= a1;
  end
  assign bus2.mmio_rd_data = d2 ? (32'hC0DE0000 | {11'h0, a2}) : 32'hBAD0BAD0;

  // ---------------- scoreboard ----------------
  logic [53:0] exp_q[$];
  int          strobe_q[$];
  int          strobes2, rd_cyc2, wr_cyc2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (bus0.mmio_cs || bus0.mmio_wr || bus0.mmio_rd)) begin
      check("cs_eq_wr_or_rd", bus0.mmio_cs, bus0.mmio_wr | bus0.mmio_rd);
      check("wr_rd_exclusive", bus0.mmio_wr & bus0.mmio_rd, 0);
      strobe_q.push_back(cyc);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("strobe_cmd",
              {bus0.mmio_wr, bus0.mmio_addr, bus0.mmio_wr ? bus0.mmio_wr_data : 32'h0},
              exp_q.pop_front());
    end
    if (!reset && bus2.mmio_cs) begin
      strobes2++;
      if (bus2.mmio_rd) rd_cyc2 = cyc;
      if (bus2.mmio_wr) wr_cyc2 = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic w, input logic [20:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus0.cmd_valid = 1'b1;
    bus0.cmd_write = w;
    bus0.cmd_addr  = a;
    bus0.cmd_wdata = d;
    while (!bus0.cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready", bus0.cmd_ready, 1);
    exp_q.push_back({w, a, w ? d : 32'h0});
    step();
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic push_seq0(input int n, input logic [20:0] a0, input logic [31:0] d0, input bit track);
    for (int i = 0; i < n; i++) begin
      bus0.cmd_valid = 1'b1;
      bus0.cmd_write = 1'b1;
      bus0.cmd_addr  = a0 + 21'(i);
      bus0.cmd_wdata = d0 + 32'(i * 17);
      check("seq_ready", bus0.cmd_ready, 1);
      if (track) exp_q.push_back({1'b1, a0 + 21'(i), d0 + 32'(i * 17)});
      step();
    end
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy0) && n < 100) begin
      step();
      n++;
    end
    check("drain_bounded", n < 100, 1);
  endtask

  task automatic wait_rsp0();
    int n;
    n = 0;
    while (!bus0.rsp_valid && n < 30) begin
      step();
      n++;
    end
    check("rsp_valid_bounded", bus0.rsp_valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, hs;
    checks   = 0;
    errors   = 0;
    strobes2 = 0;
    rd_cyc2  = 0;
    wr_cyc2  = 0;
    reset    = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus0.rsp_ready = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_addr = '0; bus2.cmd_wdata = '0;
    bus2.rsp_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_cmd_ready", bus0.cmd_ready, 1);
    check("rst_cmd_count", cnt0, 0);
    check("rst_busy", busy0, 0);
    check("rst_rsp_valid", bus0.rsp_valid, 0);
    check("rst_mmio_cs", bus0.mmio_cs, 0);
    check("rst_mmio_addr", bus0.mmio_addr, 0);
    check("rst_mmio_wr_data", bus0.mmio_wr_data, 0);
    check("rst_rsp_data", bus0.rsp_data, 0);
    check("rst_rsp_addr", bus0.rsp_addr, 0);

    // Single write: strobe two cycles after the push, exactly one cycle long
    push0(1'b1, 21'h000C2, 32'h000000A5);
    check("w1_count", cnt0, 1);
    step();
    check("w1_cs", bus0.mmio_cs, 1);
    check("w1_wr", bus0.mmio_wr, 1);
    check("w1_rd", bus0.mmio_rd, 0);
    check("w1_addr", bus0.mmio_addr, 21'h000C2);
    check("w1_data", bus0.mmio_wr_data, 32'h000000A5);
    check("w1_busy_during", busy0, 1);
    step();
    check("w1_cs_one_cycle", bus0.mmio_cs, 0);
    check("w1_no_rsp", bus0.rsp_valid, 0);
    check("w1_busy_after", busy0, 0);
    check("w1_addr_held", bus0.mmio_addr, 21'h000C2);

    // Eight back-to-back writes on an idle bus: consecutive strobes in order
    strobe_q.delete();
    push_seq0(8, 21'h00100, 32'h00001000, 1'b1);
    drain0();
    check("b2b_strobe_count", strobe_q.size(), 8);
    if (strobe_q.size() == 8) check("b2b_no_gaps", strobe_q[7] - strobe_q[0], 7);
    check("b2b_count_zero", cnt0, 0);

    // RD_LAT=0 read, response held five cycles
    push0(1'b0, 21'h000C0, 32'h0);
    step();
    check("r0_strobe", bus0.mmio_rd, 1);
    check("r0_rsp_not_yet", bus0.rsp_valid, 0);
    step();
    check("r0_rsp_valid", bus0.rsp_valid, 1);
    check("r0_rsp_data", bus0.rsp_data, 32'h12345678);
    check("r0_rsp_addr", bus0.rsp_addr, 21'h000C0);
    check("r0_state_rsp", dbg0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("r0_hold_valid", bus0.rsp_valid, 1);
      check("r0_hold_data", bus0.rsp_data, 32'h12345678);
    end
    bus0.rsp_ready = 1'b1;
    step();
    bus0.rsp_ready = 1'b0;
    check("r0_valid_drop", bus0.rsp_valid, 0);
    check("r0_busy_after", busy0, 0);

    // RD_LAT=2: read then write; write waits for the handshake
    bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b0; bus2.cmd_addr = 21'h00040;
    step();
    bus2.cmd_write = 1'b1; bus2.cmd_addr = 21'h00041; bus2.cmd_wdata = 32'h7;
    step();
    bus2.cmd_valid = 1'b0;
    n = 0;
    while (!bus2.rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("r2_rsp_valid", bus2.rsp_valid, 1);
    check("r2_latency", cyc - rd_cyc2, 3);
    check("r2_rsp_data", bus2.rsp_data, 32'hC0DE0040);
    check("r2_rsp_addr", bus2.rsp_addr, 21'h00040);
    check("r2_write_held", strobes2, 1);
    step();
    step();
    check("r2_write_still_held", strobes2, 1);
    check("r2_hold_valid", bus2.rsp_valid, 1);
    bus2.rsp_ready = 1'b1;
    hs = cyc;
    step();
    bus2.rsp_ready = 1'b0;
    check("r2_valid_drop", bus2.rsp_valid, 0);
    check("r2_wr_strobe", bus2.mmio_wr, 1);
    check("r2_wr_addr", bus2.mmio_addr, 21'h00041);
    check("r2_wr_data", bus2.mmio_wr_data, 32'h7);
    step();
    check("r2_wr_cycle", wr_cyc2, hs + 1);
    check("r2_strobe_total", strobes2, 2);

    // Fill FIFO behind a held read, push three extra, then drain eight
    push0(1'b0, 21'h000AA, 32'h0);
    push_seq0(8, 21'h00200, 32'h00002000, 1'b1);
    check("full_count", cnt0, 8);
    check("full_ready_low", bus0.cmd_ready, 0);
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1;
    bus0.cmd_addr = 21'h1FFFF; bus0.cmd_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_extra_count", cnt0, 8);
      check("full_extra_ready", bus0.cmd_ready, 0);
    end
    bus0.cmd_valid = 1'b0;
    check("full_rsp_data", bus0.rsp_data, 32'h12345612);
    strobe_q.delete();
    bus0.rsp_ready = 1'b1;
    step();
    bus0.rsp_ready = 1'b0;
    drain0();
    check("full_strobe_count", strobe_q.size(), 8);
    if (strobe_q.size() == 8) check("full_no_gaps", strobe_q[7] - strobe_q[0], 7);
    check("full_count_zero", cnt0, 0);

    // Reset during RSP with three writes queued
    push0(1'b0, 21'h000C0, 32'h0);
    push_seq0(3, 21'h00300, 32'h00003000, 1'b0);
    wait_rsp0();
    check("rr_queued", cnt0, 3);
    strobe_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_rsp_valid", bus0.rsp_valid, 0);
    check("rr_count", cnt0, 0);
    check("rr_cs", bus0.mmio_cs, 0);
    check("rr_busy", busy0, 0);
    check("rr_ready", bus0.cmd_ready, 1);
    repeat (4) step();
    check("rr_no_strobes", strobe_q.size(), 0);

    // Fresh read with rsp_ready already high
    bus0.rsp_ready = 1'b1;
    push0(1'b0, 21'h000AB, 32'h0);
    wait_rsp0();
    check("fr_rsp_data", bus0.rsp_data, 32'h12345613);
    check("fr_rsp_addr", bus0.rsp_addr, 21'h000AB);
    step();
    bus0.rsp_ready = 1'b0;
    check("fr_valid_drop", bus0.rsp_valid, 0);
    check("fr_busy", busy0, 0);
    check("fr_exp_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
